// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the fetch/data memory arbiter.
package arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ACK  = 2'b10
    } arbState_t;

    typedef enum logic {
        OWN_D  = 1'b0,
        OWN_IF = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side (fetch + load/store) and memory-side signals of the arbiter.
// slave = arbiter view, master = core/memory environment view.
interface mem_arbiter_if
    import arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stall;
    logic              busy;
    logic              bus_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
               stall, busy, bus_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
               stall, busy, bus_err
    );

endinterface

// File: rtl/mem_arbiter_timeout_cnt.sv
// BUSY watchdog for the memory arbiter; only compiled with ARB_TIMEOUT_EN,
// which is also the only build that instantiates it.
`ifdef ARB_TIMEOUT_EN
module arb_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // expired marks the last tolerated BUSY cycle; the abort happens on its edge
    assign expired = en && (cnt == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and data.
// Optional BUSY watchdog with bus_err abort: define ARB_TIMEOUT_EN.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    arbState_t         state;
    owner_t            owner;
    logic              rr;
    logic              memEn;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] ifRdata;
    logic [DATA_W-1:0] dRdata;
    logic              ifAck;
    logic              dAck;
    logic              anyReq;
    logic              grantIf;

    assign anyReq  = bus.if_req | bus.d_req;
    // rr=0 favours data, rr=1 favours fetch; it only matters on a tie
    assign grantIf = bus.if_req & (~bus.d_req | rr);

`ifdef ARB_TIMEOUT_EN
    logic busErr;
    logic tmoExpired;

    arb_timeout_cnt #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == IDLE),
        .en     (state == BUSY),
        .expired(tmoExpired)
    );

    assign bus.bus_err = busErr;
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT_CYC > 0);
    assign bus.bus_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= OWN_D;
            rr       <= 1'b0;
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            ifRdata  <= '0;
            dRdata   <= '0;
            ifAck    <= 1'b0;
            dAck     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            busErr   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        owner    <= grantIf ? OWN_IF : OWN_D;
                        memEn    <= 1'b1;
                        memWe    <= grantIf ? 1'b0 : bus.d_we;
                        memAddr  <= grantIf ? bus.if_addr : bus.d_addr;
                        memWdata <= grantIf ? '0 : bus.d_wdata;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        memEn <= 1'b0;
                        if (owner == OWN_IF) begin
                            ifRdata <= bus.mem_rdata;
                            ifAck   <= 1'b1;
                        end else begin
                            if (!memWe) begin
                                dRdata <= bus.mem_rdata;
                            end
                            dAck <= 1'b1;
                        end
                        rr    <= (owner == OWN_D);
                        state <= ACK;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmoExpired) begin
                        memEn <= 1'b0;
                        if (owner == OWN_IF) begin
                            ifRdata <= '0;
                            ifAck   <= 1'b1;
                        end else begin
                            dRdata <= '0;
                            dAck   <= 1'b1;
                        end
                        busErr <= 1'b1;
                        rr     <= (owner == OWN_D);
                        state  <= ACK;
                    end
`endif
                end
                ACK: begin
                    ifAck <= 1'b0;
                    dAck  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    busErr <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = memEn;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.if_rdata  = ifRdata;
    assign bus.d_rdata   = dRdata;
    assign bus.if_ack    = ifAck;
    assign bus.d_ack     = dAck;
    assign bus.busy      = (state != IDLE);
    assign bus.stall     = (bus.if_req & ~ifAck) | (bus.d_req & ~dAck);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected grants/acks,
// independent monitors pop and compare when the DUT presents them.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    grant_t expGrant[$];
    resp_t  expIf[$];
    resp_t  expD[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int waitStates = 0;
    bit stuck = 1'b0;
    int waitCnt = 0;
    bit prevEn = 1'b0;
    int enRun = 0;
    int lastEnRun = 0;
    logic [31:0] heldAddr = '0;
    bit prevIfAck = 1'b0;
    bit prevDAck = 1'b0;
    bit busErrSeen = 1'b0;
    int ifAckCyc = 0;
    int dAckCyc = 0;
    int ifAckCount = 0;
    int dAckCount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] memData(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h8C01_0004;
            32'h0000_0200: return 32'hCAFE_F00D;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    function automatic grant_t mkGrant(input logic we, input logic [31:0] a, input logic [31:0] wd);
        grant_t g;
        g.we = we; g.addr = a; g.wdata = wd;
        return g;
    endfunction

    function automatic resp_t mkResp(input logic [31:0] rd, input logic err);
        resp_t r;
        r.rdata = rd; r.err = err;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory model: ready after waitStates BUSY cycles, never while stuck
    initial forever begin
        @(negedge clk);
        if (bus.mem_en) begin
            if (!stuck && waitCnt >= waitStates) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = memData(bus.mem_addr);
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 32'hBAD0_BAD0;
                waitCnt++;
            end
        end else begin
            bus.mem_ready = 1'b0;
            waitCnt = 0;
        end
    end

    // grant monitor
    initial forever begin
        @(negedge clk);
        if (bus.mem_en) begin
            if (!prevEn) begin
                if (expGrant.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant actual=%h required=none", bus.mem_addr);
                end else begin
                    grant_t g;
                    g = expGrant.pop_front();
                    check("grant_we", {31'd0, bus.mem_we}, {31'd0, g.we});
                    check("grant_addr", bus.mem_addr, g.addr);
                    if (g.we) check("grant_wdata", bus.mem_wdata, g.wdata);
                end
            end else begin
                check("addr_stable", bus.mem_addr, heldAddr);
            end
            heldAddr = bus.mem_addr;
            enRun++;
        end else begin
            if (prevEn) lastEnRun = enRun;
            enRun = 0;
        end
        prevEn = bus.mem_en;
    end

    // ack monitor
    initial forever begin
        @(negedge clk);
        if (bus.bus_err) busErrSeen = 1'b1;
        if (bus.bus_err && !bus.if_ack && !bus.d_ack) begin
            checks++; errors++;
            $display("FAIL bus_err_without_ack actual=1 required=0");
        end
        if (bus.if_ack) begin
            check("if_ack_width", {31'd0, prevIfAck}, 32'd0);
            ifAckCyc = cyc; ifAckCount++;
            if (expIf.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_if_ack actual=1 required=0");
            end else begin
                resp_t r;
                r = expIf.pop_front();
                check("if_rdata", bus.if_rdata, r.rdata);
                check("if_bus_err", {31'd0, bus.bus_err}, {31'd0, r.err});
            end
        end
        if (bus.d_ack) begin
            check("d_ack_width", {31'd0, prevDAck}, 32'd0);
            dAckCyc = cyc; dAckCount++;
            if (expD.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_d_ack actual=1 required=0");
            end else begin
                resp_t r;
                r = expD.pop_front();
                check("d_rdata", bus.d_rdata, r.rdata);
                check("d_bus_err", {31'd0, bus.bus_err}, {31'd0, r.err});
            end
        end
        prevIfAck = bus.if_ack;
        prevDAck  = bus.d_ack;
    end

    task automatic fetch(input logic [31:0] a, input resp_t exp);
        bit got;
        got = 1'b0;
        expIf.push_back(exp);
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.if_ack) got = 1'b1;
        end
        check("if_ack_seen", {31'd0, got}, 32'd1);
        bus.if_req = 1'b0;
    endtask

    task automatic dAccess(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input resp_t exp);
        bit got;
        got = 1'b0;
        expD.push_back(exp);
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        bus.d_req   = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.d_ack) got = 1'b1;
        end
        check("d_ack_seen", {31'd0, got}, 32'd1);
        bus.d_req = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int dBefore;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;

        // reset state
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        check("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // single fetch, zero wait states
        expGrant.push_back(mkGrant(1'b0, 32'h40, 32'h0));
        fetch(32'h40, mkResp(32'h8C01_0004, 1'b0));
        @(negedge clk);
        check("fetch_en_cycles", lastEnRun, 32'd1);
        check("fetch_stall_after", {31'd0, bus.stall}, 32'd0);
        check("fetch_if_rdata_hold", bus.if_rdata, 32'h8C01_0004);

        // simultaneous requests after reset: data wins, fetch 3 cycles later
        doReset();
        expGrant.push_back(mkGrant(1'b1, 32'h100, 32'hA5A5_A5A5));
        expGrant.push_back(mkGrant(1'b0, 32'h80, 32'h0));
        fork
            dAccess(1'b1, 32'h100, 32'hA5A5_A5A5, mkResp(32'h0, 1'b0));
            fetch(32'h80, mkResp(32'h5A5A_0080, 1'b0));
            begin
                @(negedge clk);
                check("stall_loser", {31'd0, bus.stall}, 32'd1);
            end
        join
        @(negedge clk);
        check("ack_spacing", ifAckCyc - dAckCyc, 32'd3);

        // fairness with continuous requests
        doReset();
        expGrant.push_back(mkGrant(1'b0, 32'h300, 32'h0));
        expGrant.push_back(mkGrant(1'b0, 32'h1000, 32'h0));
        expGrant.push_back(mkGrant(1'b0, 32'h304, 32'h0));
        expGrant.push_back(mkGrant(1'b0, 32'h1004, 32'h0));
        expGrant.push_back(mkGrant(1'b0, 32'h308, 32'h0));
        expGrant.push_back(mkGrant(1'b0, 32'h1008, 32'h0));
        fork
            for (int i = 0; i < 3; i++) begin
                if (i > 0) @(negedge clk);
                dAccess(1'b0, 32'h300 + 32'(4 * i), 32'h0, mkResp(32'h5A5A_0300 + 32'(4 * i), 1'b0));
            end
            for (int j = 0; j < 3; j++) begin
                if (j > 0) @(negedge clk);
                fetch(32'h1000 + 32'(4 * j), mkResp(32'h5A5A_1000 + 32'(4 * j), 1'b0));
            end
        join
        @(negedge clk);
        check("fair_grants_left", expGrant.size(), 32'd0);

        // wait states, then a store must not disturb d_rdata
        waitStates = 4;
        expGrant.push_back(mkGrant(1'b0, 32'h200, 32'h0));
        dAccess(1'b0, 32'h200, 32'h0, mkResp(32'hCAFE_F00D, 1'b0));
        @(negedge clk);
        check("wait_en_cycles", lastEnRun, 32'd5);
        waitStates = 0;
        expGrant.push_back(mkGrant(1'b1, 32'h204, 32'h1234_5678));
        dAccess(1'b1, 32'h204, 32'h1234_5678, mkResp(32'hCAFE_F00D, 1'b0));

        // reset during BUSY: access discarded, held request re-serviced
        @(negedge clk);
        dBefore = dAckCount;
        stuck = 1'b1;
        expGrant.push_back(mkGrant(1'b0, 32'h240, 32'h0));
        expGrant.push_back(mkGrant(1'b0, 32'h240, 32'h0));
        fork
            dAccess(1'b0, 32'h240, 32'h0, mkResp(32'h5A5A_0240, 1'b0));
            begin
                repeat (3) @(negedge clk);
                check("mid_busy", {31'd0, bus.busy}, 32'd1);
                #2 rst = 1'b0;
                #1;
                check("mid_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
                check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
                check("mid_rst_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
                @(negedge clk);
                stuck = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        join
        @(negedge clk);
        check("mid_rst_ack_count", dAckCount - dBefore, 32'd1);

`ifdef ARB_TIMEOUT_EN
        stuck = 1'b1;
        expGrant.push_back(mkGrant(1'b0, 32'h280, 32'h0));
        dAccess(1'b0, 32'h280, 32'h0, mkResp(32'h0, 1'b1));
        @(negedge clk);
        check("tmo_en_cycles", lastEnRun, 32'd16);
        check("tmo_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("tmo_d_rdata", bus.d_rdata, 32'd0);
        stuck = 1'b0;
`else
        stuck = 1'b1;
        dBefore = dAckCount;
        busErrSeen = 1'b0;
        expGrant.push_back(mkGrant(1'b0, 32'h280, 32'h0));
        bus.d_we = 1'b0; bus.d_addr = 32'h280; bus.d_req = 1'b1;
        repeat (40) @(negedge clk);
        check("stuck_busy", {31'd0, bus.busy}, 32'd1);
        check("stuck_mem_en", {31'd0, bus.mem_en}, 32'd1);
        check("stuck_bus_err", {31'd0, busErrSeen}, 32'd0);
        check("stuck_no_ack", dAckCount - dBefore, 32'd0);
        rst = 1'b0;
        bus.d_req = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`endif

        check("grants_left", expGrant.size(), 32'd0);
        check("if_resp_left", expIf.size(), 32'd0);
        check("d_resp_left", expD.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
